// File: rtl/ntt_bank_mapper.sv
// ntt_bank_mapper
// Two-stage pipeline that maps the 16 butterfly operand orders of one
// radix-16 group onto 16 coefficient SRAM banks.
//   S1: bank = radix-16 digit sum mod 16, in-bank address = order >> 4.
//   S2: per-bank inversion (lowest order index wins), read enables,
//       crossbar select, sticky conflict flag and group counter.
module ntt_bank_mapper #(
    parameter int LOGN     = 12,
    parameter int RADIX_K1 = 4,
    parameter int AW       = LOGN - RADIX_K1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16*LOGN-1:0]   order_in,
    input  logic                 in_valid,
    input  logic                 in_done,
    output logic [16*AW-1:0]     bank_addr,
    output logic [15:0]          bank_rd_en,
    output logic [63:0]          perm_sel,
    output logic                 out_valid,
    output logic                 out_done,
    output logic                 conflict_err,
    output logic [15:0]          group_cnt
);

    localparam int NB   = 16;
    localparam int NDIG = LOGN / 4;

    // Bank of an order: wrap-around 4-bit sum of its radix-16 digits.
    function automatic logic [3:0] digit_sum(input logic [LOGN-1:0] ord);
        logic [3:0] acc;
        acc = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            acc = acc + ord[4*i +: 4];
        end
        return acc;
    endfunction

    // Stage 1 registers
    logic [3:0]                r_s1_bank [NB];
    logic [AW-1:0]             r_s1_addr [NB];
    logic                      r_s1_valid;
    logic                      r_s1_done;

    // Stage 2 inversion results (combinational)
    logic [NB-1:0][AW-1:0]     w_addr;
    logic [NB-1:0][3:0]        w_perm;
    logic [NB-1:0]             w_hit;
    logic                      w_conflict;

    // Stage 2 registers
    logic [NB-1:0][AW-1:0]     r_bank_addr;
    logic [NB-1:0][3:0]        r_perm_sel;
    logic [NB-1:0]             r_rd_en;
    logic                      r_out_valid;
    logic                      r_out_done;
    logic                      r_conflict;
    logic [15:0]               r_group_cnt;

    // Stage 1: split each order into bank and in-bank address, track valid/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NB; k++) begin
                r_s1_bank[k] <= 4'd0;
                r_s1_addr[k] <= '0;
            end
            r_s1_valid <= 1'b0;
            r_s1_done  <= 1'b0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                r_s1_bank[k] <= digit_sum(order_in[k*LOGN +: LOGN]);
                r_s1_addr[k] <= order_in[k*LOGN+RADIX_K1 +: AW];
            end
            r_s1_valid <= in_valid;
            r_s1_done  <= in_done;
        end
    end

    // Invert order->bank into bank->order; the first (lowest) order claiming a bank wins,
    // any later claim of an already-taken bank flags a conflict.
    always_comb begin
        w_addr     = '0;
        w_perm     = '0;
        w_hit      = 16'h0000;
        w_conflict = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (w_hit[r_s1_bank[k]]) begin
                w_conflict = 1'b1;
            end else begin
                w_hit[r_s1_bank[k]]  = 1'b1;
                w_addr[r_s1_bank[k]] = r_s1_addr[k];
                w_perm[r_s1_bank[k]] = 4'(k);
            end
        end
    end

    // Stage 2: register bank drive; bubbles drive all-zero bank controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_addr <= '0;
            r_perm_sel  <= '0;
            r_rd_en     <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_done  <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_done  <= r_s1_done;
            r_conflict  <= r_conflict | (r_s1_valid & w_conflict);
            if (r_s1_valid) begin
                r_bank_addr <= w_addr;
                r_perm_sel  <= w_perm;
                r_rd_en     <= w_hit;
            end else begin
                r_bank_addr <= '0;
                r_perm_sel  <= '0;
                r_rd_en     <= 16'h0000;
            end
        end
    end

    // Group counter: counts emitted groups, restarts after the done group.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_group_cnt <= 16'd0;
        end else if (r_out_done) begin
            r_group_cnt <= 16'd0;
        end else if (r_out_valid) begin
            r_group_cnt <= r_group_cnt + 16'd1;
        end else begin
            r_group_cnt <= r_group_cnt;
        end
    end

    assign bank_addr    = r_bank_addr;
    assign perm_sel     = r_perm_sel;
    assign bank_rd_en   = r_rd_en;
    assign out_valid    = r_out_valid;
    assign out_done     = r_out_done;
    assign conflict_err = r_conflict;
    assign group_cnt    = r_group_cnt;

endmodule

// File: tb/tb_ntt_bank_mapper.sv
// tb_ntt_bank_mapper
// Directed groups from the block's test list followed by randomized traffic,
// all checked cycle by cycle against a behavioural bank-mapping model.
`timescale 1ns/1ps
module tb_ntt_bank_mapper;

    logic          clk;
    logic          rst;
    logic [191:0]  order_in;
    logic          in_valid;
    logic          in_done;
    logic [127:0]  bank_addr;
    logic [15:0]   bank_rd_en;
    logic [63:0]   perm_sel;
    logic          out_valid;
    logic          out_done;
    logic          conflict_err;
    logic [15:0]   group_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    // model state: group accepted on the previous step, sticky error, counter
    logic [191:0]  p_ord;
    logic          p_valid;
    logic          p_done;
    logic          m_err;
    logic [15:0]   m_cnt;

    ntt_bank_mapper dut (
        .clk          (clk),
        .rst          (rst),
        .order_in     (order_in),
        .in_valid     (in_valid),
        .in_done      (in_done),
        .bank_addr    (bank_addr),
        .bank_rd_en   (bank_rd_en),
        .perm_sel     (perm_sel),
        .out_valid    (out_valid),
        .out_done     (out_done),
        .conflict_err (conflict_err),
        .group_cnt    (group_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural mapping: bank = digit sum mod 16, addr = order/16,
    // each bank served by the lowest order index that lands on it.
    task automatic ref_map(input logic [191:0] ord, output logic [15:0] en,
                           output logic [63:0] perm, output logic [127:0] addr,
                           output logic conf);
        int bank [16];
        int ad   [16];
        en = 16'h0; perm = 64'h0; addr = 128'h0; conf = 1'b0;
        for (int k = 0; k < 16; k++) begin
            int o;
            o = int'(ord[k*12 +: 12]);
            bank[k] = ((o % 16) + ((o / 16) % 16) + (o / 256)) % 16;
            ad[k]   = o / 16;
        end
        for (int b = 0; b < 16; b++) begin
            int hits;
            hits = 0;
            for (int k = 0; k < 16; k++) begin
                if (bank[k] == b) begin
                    if (hits == 0) begin
                        en[b] = 1'b1;
                        perm[b*4 +: 4] = 4'(k);
                        addr[b*8 +: 8] = 8'(ad[k]);
                    end
                    hits++;
                end
            end
            if (hits > 1) conf = 1'b1;
        end
    endtask

    // Apply one cycle of stimulus, then check outputs after the edge.
    task automatic step(input logic [191:0] ord, input logic v, input logic d, input logic r);
        logic [15:0]  e_en;
        logic [63:0]  e_perm;
        logic [127:0] e_addr;
        logic         e_conf;
        order_in = ord; in_valid = v; in_done = d; rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            m_err = 1'b0; m_cnt = 16'd0;
            check("rst_valid", 128'(out_valid), 128'(0));
            check("rst_done",  128'(out_done), 128'(0));
            check("rst_rden",  128'(bank_rd_en), 128'(0));
            check("rst_perm",  128'(perm_sel), 128'(0));
            check("rst_addr",  bank_addr, 128'(0));
            check("rst_err",   128'(conflict_err), 128'(0));
            check("rst_cnt",   128'(group_cnt), 128'(0));
            p_ord = '0; p_valid = 1'b0; p_done = 1'b0;
        end else begin
            check("out_valid", 128'(out_valid), 128'(p_valid));
            check("out_done",  128'(out_done), 128'(p_done));
            check("group_cnt", 128'(group_cnt), 128'(m_cnt));
            if (p_valid) begin
                ref_map(p_ord, e_en, e_perm, e_addr, e_conf);
                m_err = m_err | e_conf;
                check("rd_en",     128'(bank_rd_en), 128'(e_en));
                check("perm_sel",  128'(perm_sel), 128'(e_perm));
                check("bank_addr", bank_addr, e_addr);
            end else begin
                check("bubble_rden", 128'(bank_rd_en), 128'(0));
                check("bubble_perm", 128'(perm_sel), 128'(0));
            end
            check("conflict_err", 128'(conflict_err), 128'(m_err));
            if (p_done)       m_cnt = 16'd0;
            else if (p_valid) m_cnt = m_cnt + 16'd1;
            p_ord = ord; p_valid = v; p_done = d;
        end
    endtask

    // Conflict-free AGU-style group: one digit position sweeps 0..15.
    function automatic logic [191:0] legal_group();
        logic [191:0] g;
        logic [11:0]  base;
        int           pos;
        base = 12'($urandom);
        pos  = $urandom_range(0, 2);
        for (int k = 0; k < 16; k++) begin
            logic [11:0] o;
            o = base;
            o[pos*4 +: 4] = 4'(k);
            g[k*12 +: 12] = o;
        end
        return g;
    endfunction

    function automatic logic [191:0] random_group();
        logic [191:0] g;
        for (int k = 0; k < 16; k++) g[k*12 +: 12] = 12'($urandom);
        return g;
    endfunction

    initial begin
        logic [191:0] g;
        p_ord = '0; p_valid = 1'b0; p_done = 1'b0; m_err = 1'b0; m_cnt = 16'd0;
        order_in = '0; in_valid = 1'b0; in_done = 1'b0; rst = 1'b1;

        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);

        // orders k*256: bank b gets order b at address 16*b
        for (int k = 0; k < 16; k++) g[k*12 +: 12] = 12'(k * 256);
        step(g, 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        check("t1_rden", 128'(bank_rd_en), 128'(16'hFFFF));
        check("t1_addr5", 128'(bank_addr[5*8 +: 8]), 128'(8'h50));
        step('0, 1'b0, 1'b0, 1'b0);

        // orders 0x120+k: bank (3+k)%16, all addresses 0x12
        for (int k = 0; k < 16; k++) g[k*12 +: 12] = 12'(12'h120 + k);
        step(g, 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        check("t2_perm0", 128'(perm_sel[3:0]), 128'(4'd13));
        step('0, 1'b0, 1'b0, 1'b0);

        // all orders 0x005: single bank 5, sticky conflict
        for (int k = 0; k < 16; k++) g[k*12 +: 12] = 12'h005;
        step(g, 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        check("t3_rden", 128'(bank_rd_en), 128'(16'h0020));
        check("t3_err",  128'(conflict_err), 128'(1));
        for (int i = 0; i < 10; i++) step('0, 1'b0, 1'b0, 1'b0);
        check("t3_err_sticky", 128'(conflict_err), 128'(1));
        step('0, 1'b0, 1'b0, 1'b1);

        // 20 back-to-back groups, done on the last
        for (int i = 0; i < 20; i++) step(legal_group(), 1'b1, (i == 19), 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        check("t4_cnt19", 128'(group_cnt), 128'(16'd19));
        check("t4_done",  128'(out_done), 128'(1));
        step('0, 1'b0, 1'b0, 1'b0);
        check("t4_cnt0",  128'(group_cnt), 128'(16'd0));

        // reset with two groups in flight
        for (int k = 0; k < 16; k++) g[k*12 +: 12] = 12'h005;
        step(g, 1'b1, 1'b0, 1'b0);
        step(legal_group(), 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        check("t5_err", 128'(conflict_err), 128'(0));

        // alternating valid/bubble
        for (int i = 0; i < 20; i++) step(legal_group(), 1'(i % 2 == 0), 1'b0, 1'b0);

        // randomized traffic: legal and arbitrary groups, stray done pulses, resets
        for (int i = 0; i < 400; i++) begin
            logic v, d, r;
            v = 1'($urandom_range(0, 3) != 0);
            d = 1'($urandom_range(0, 15) == 0);
            r = 1'($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 3) == 0) g = random_group();
            else                           g = legal_group();
            step(g, v, d, r);
        end
        step('0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
